// File: rtl/host_mailbox_pkg.sv
// Shared constants for the CPU-to-host mailbox: register word offsets and STATUS layout.
package host_mailbox_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_EXIT   = 3'd2;

  localparam int STATUS_FULL      = 0;
  localparam int STATUS_EMPTY     = 1;
  localparam int STATUS_OVF       = 2;
  localparam int STATUS_LEVEL_LSB = 8;
  localparam int STATUS_LEVEL_W   = 8;

endpackage

// File: rtl/host_mailbox_fifo.sv
// Synchronous FIFO for the mailbox: registered level, head word shown combinationally
// (forced to zero while empty).
module host_mailbox_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DW-1:0]         data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DW-1:0]         head
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LEVEL_W = DEPTH_LOG2 + 1;

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; the empty gate on head keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/host_mailbox.sv
// Wishbone B3 slave carrying CPU result words and an exit code to the host.
// Optional HOST_MAILBOX_ERR_EN: DATA write while full returns wb_err_o instead of stalling.
module host_mailbox
  import host_mailbox_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DW         = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [2:0]    wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [DW-1:0] host_data_o,
  output logic          host_valid_o,
  input  logic          host_ack_i,
  output logic          exit_valid_o,
  output logic [DW-1:0] exit_code_o
);

  logic                unused;
  logic                req;
  logic                wr_data;
  logic                ack_hit;
  logic                err_hit;
  logic                push;
  logic                pop;
  logic                ovf;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_level;
  logic [DW-1:0]       status_word;
  logic [DW-1:0]       rd_data;

  assign unused = ^{wb_sel_i, wb_cti_i, wb_bte_i};

  // A new request is only taken when no response is on the bus this cycle.
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr_data = req & wb_we_i & (wb_adr_i == ADDR_DATA);
  assign ack_hit = req & ~(wr_data & fifo_full);
  assign push    = wr_data & ~fifo_full;
  assign pop     = host_ack_i & ~fifo_empty;

`ifdef HOST_MAILBOX_ERR_EN
  assign err_hit = wr_data & fifo_full;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)     ovf <= 1'b0;
    else if (err_hit) ovf <= 1'b1;
  end
`else
  assign err_hit = 1'b0;
  assign ovf     = 1'b0;
`endif

  host_mailbox_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DW        (DW)
  ) u_fifo (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .push (push),
    .pop  (pop),
    .data (wb_dat_i),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level),
    .head (host_data_o)
  );

  assign host_valid_o = ~fifo_empty;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    status_word = '0;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_OVF]   = ovf;
    status_word[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = STATUS_LEVEL_W'(fifo_level);
  end

  always_comb begin
    rd_data = '0;
    if (!wb_we_i) begin
      case (wb_adr_i)
        ADDR_STATUS: rd_data = status_word;
        ADDR_EXIT:   rd_data = exit_code_o;
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= '0;
      exit_valid_o <= 1'b0;
      exit_code_o  <= '0;
    end else begin
      wb_ack_o <= ack_hit;
      wb_err_o <= err_hit;
      wb_dat_o <= ack_hit ? rd_data : '0;
      if (ack_hit && wb_we_i && (wb_adr_i == ADDR_EXIT)) begin
        exit_valid_o <= 1'b1;
        exit_code_o  <= wb_dat_i;
      end
    end
  end

endmodule
